// File: rtl/alu_unit_pkg.sv
// Op-type codes shared with the reservation station and decoder, plus the
// default ROB tag width used by the ALU issue/CDB path.
package alu_unit_pkg;

  localparam int ROB_W = 4;

  typedef enum logic [5:0] {
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10, OP_LB    = 6'd11, OP_LH    = 6'd12,
    OP_LW    = 6'd13, OP_LBU   = 6'd14, OP_LHU   = 6'd15, OP_SB    = 6'd16,
    OP_SH    = 6'd17, OP_SW    = 6'd18, OP_ADDI  = 6'd19, OP_SLTI  = 6'd20,
    OP_SLTIU = 6'd21, OP_XORI  = 6'd22, OP_ORI   = 6'd23, OP_ANDI  = 6'd24,
    OP_SLLI  = 6'd25, OP_SRLI  = 6'd26, OP_SRAI  = 6'd27, OP_ADD   = 6'd28,
    OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31, OP_SLTU  = 6'd32,
    OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35, OP_OR    = 6'd36,
    OP_AND   = 6'd37
  } op_e;

endpackage

// File: rtl/alu_unit_if.sv
// RS->ALU issue signals and ALU->CDB broadcast handshake.
interface alu_unit_if #(parameter int ROB_W = 4);
  logic             mission;
  logic [5:0]       op_type;
  logic [31:0]      rs1;
  logic [31:0]      rs2;
  logic [ROB_W-1:0] rob_dest;
  logic             busy;

  logic             cdb_req;
  logic             cdb_grant;
  logic [ROB_W-1:0] cdb_rob_dest;
  logic [31:0]      cdb_value;
  logic             cdb_is_branch;
  logic             cdb_taken;

  modport master (
    output mission, op_type, rs1, rs2, rob_dest, cdb_grant,
    input  busy, cdb_req, cdb_rob_dest, cdb_value, cdb_is_branch, cdb_taken
  );

  modport slave (
    input  mission, op_type, rs1, rs2, rob_dest, cdb_grant,
    output busy, cdb_req, cdb_rob_dest, cdb_value, cdb_is_branch, cdb_taken
  );
endinterface

// File: rtl/alu_unit_core.sv
// Pure combinational datapath: op_type/operands -> result, branch flag, outcome.
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [5:0]  op_type,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] value,
  output logic        is_branch,
  output logic        taken
);

  logic [4:0]  shamt;
  logic [31:0] sum;
  logic        lt_s;
  logic        lt_u;

  assign shamt = rs2[4:0];
  assign sum   = rs1 + rs2;
  assign lt_s  = $signed(rs1) < $signed(rs2);
  assign lt_u  = rs1 < rs2;

  always_comb begin
    value     = '0;
    is_branch = 1'b0;
    taken     = 1'b0;
    case (op_e'(op_type))
      OP_ADD, OP_ADDI:   value = sum;
      OP_SUB:            value = rs1 - rs2;
      OP_AND, OP_ANDI:   value = rs1 & rs2;
      OP_OR,  OP_ORI:    value = rs1 | rs2;
      OP_XOR, OP_XORI:   value = rs1 ^ rs2;
      OP_SLL, OP_SLLI:   value = rs1 << shamt;
      OP_SRL, OP_SRLI:   value = rs1 >> shamt;
      OP_SRA, OP_SRAI:   value = $unsigned($signed(rs1) >>> shamt);
      OP_SLT, OP_SLTI:   value = {31'b0, lt_s};
      OP_SLTU, OP_SLTIU: value = {31'b0, lt_u};
      OP_JALR:           value = sum & ~32'h1;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        is_branch = 1'b1;
        case (op_e'(op_type))
          OP_BEQ:  taken = (rs1 == rs2);
          OP_BNE:  taken = (rs1 != rs2);
          OP_BLT:  taken = lt_s;
          OP_BGE:  taken = !lt_s;
          OP_BLTU: taken = lt_u;
          default: taken = !lt_u;
        endcase
        value = {31'b0, taken};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: computes issued ops and broadcasts results in issue
// order from a small queue under the CDB req/grant handshake.
module alu_unit #(
  parameter int RESQ_DEPTH = 4,
  parameter int ROB_W      = alu_unit_pkg::ROB_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  alu_unit_if.slave   bus,
  output logic        overflow_err
);

  localparam int PTR_W = $clog2(RESQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      res_value;
  logic             res_is_branch;
  logic             res_taken;

  logic [ROB_W-1:0] q_dest   [RESQ_DEPTH];
  logic [31:0]      q_value  [RESQ_DEPTH];
  logic             q_branch [RESQ_DEPTH];
  logic             q_taken  [RESQ_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic head_valid;
  logic full;
  logic accept;
  logic pop;
  logic push;

  alu_core u_core (
    .op_type   (bus.op_type),
    .rs1       (bus.rs1),
    .rs2       (bus.rs2),
    .value     (res_value),
    .is_branch (res_is_branch),
    .taken     (res_taken)
  );

  assign head_valid = (count != '0);
  assign full       = (count == CNT_W'(RESQ_DEPTH));
  assign accept     = rdy && !flush && bus.mission;
  assign pop        = rdy && !flush && head_valid && bus.cdb_grant;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push       = accept && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
        if (accept && !push)   overflow_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_dest[wr_ptr]   <= bus.rob_dest;
      q_value[wr_ptr]  <= res_value;
      q_branch[wr_ptr] <= res_is_branch;
      q_taken[wr_ptr]  <= res_taken;
    end
  end

  // Storage is not reset; gating on head_valid keeps outputs at zero when empty.
  assign bus.cdb_req       = head_valid;
  assign bus.cdb_rob_dest  = head_valid ? q_dest[rd_ptr]   : '0;
  assign bus.cdb_value     = head_valid ? q_value[rd_ptr]  : '0;
  assign bus.cdb_is_branch = head_valid && q_branch[rd_ptr];
  assign bus.cdb_taken     = head_valid && q_taken[rd_ptr];
  assign bus.busy          = (count >= CNT_W'(RESQ_DEPTH - 1));

endmodule
